bip_program_loader: RTL and testbench
=====================================

Name: bip_program_loader

Overview:
- Writer side of the BIP program memory. The fetch/decode path reads instruction words; this block produces and writes them.
- Accepts a byte stream over a valid/ready handshake, typically from a UART receiver.
- Packs two bytes into each 16-bit instruction {opcode[4:0], operand[10:0]} and writes it to program RAM at incrementing addresses.
- Stops at the HLT opcode, then releases the CPU by asserting cpu_en.

Parameters:
- ADDR_W, 11, program memory address width; depth is 2^ADDR_W words.
- OPCODE_W, 5, opcode field width; equals the decoder input width.
- INSTR_W, 16, instruction word width; operand width = INSTR_W - OPCODE_W.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  single-cycle pulse that begins a load.
- rx_data  input  8  incoming byte.
- rx_valid  input  1  rx_data is valid.
- rx_ready  output  1  loader accepts a byte this cycle.
- pm_we  output  1  program memory write strobe.
- pm_addr  output  ADDR_W  program memory write address.
- pm_wdata  output  INSTR_W  instruction word being written.
- busy  output  1  load in progress (states HI, LO, WR).
- done  output  1  load finished; held until the next start or reset.
- error  output  1  load finished abnormally; held until the next start or reset.
- instr_count  output  ADDR_W+1  number of words written in the current load.
- cpu_en  output  1  CPU run enable; high only after a clean load.

Behaviour:
- Reset (synchronous, active-high) sets:
  - state = IDLE;
  - rx_ready, pm_we, busy, done, error, cpu_en = 0;
  - pm_addr, pm_wdata, instr_count = 0.
- States:
  - IDLE: rx_ready = 0. start -> HI, and clears addr, instr_count, done, error and cpu_en.
  - HI: rx_ready = 1. A byte transfers when rx_valid && rx_ready. On transfer, latch the high byte -> LO.
  - LO: rx_ready = 1. On transfer, latch the low byte -> WR.
  - WR: rx_ready = 0. pm_we = 1 for exactly this one cycle, with pm_addr = addr and pm_wdata = {hi, lo}. instr_count increments.
    - If opcode (pm_wdata[15:11]) == 0 (HLT) -> DONE with error = 0 and cpu_en = 1.
    - Else, if addr == 2^ADDR_W - 1 -> DONE with error = 1 and cpu_en = 0 (memory full, no halt).
    - Else addr++ -> HI.
  - DONE: done = 1. start -> HI, clearing the same registers as in IDLE, including cpu_en.
- Byte order: the high byte (it carries the opcode) arrives first.
- rx_ready is a decode of the state only; it never depends combinationally on rx_valid.
- Latency: the write happens one cycle after the low byte transfers. Minimum cost is 3 cycles per instruction.
- rx_valid while not ready: the byte is not consumed; the source must hold it.
- start during HI, LO or WR is ignored.
- cpu_en is never 1 while busy = 1.
- A full memory that ends in HLT at the last address counts as a clean load (the HLT check has priority); instr_count = 2^ADDR_W.
- Reset mid-load: return to IDLE immediately and discard any partially latched byte. pm_we is deasserted that same cycle. Memory already written is not cleared.

Optional Feature:
- Macro: BIP_LOADER_OPCODE_CHECK_EN.
- Defined: in WR, an opcode greater than 7 (outside the implemented ISA) suppresses the write (pm_we = 0) and leaves instr_count unchanged. The block then goes to DONE with error = 1 and cpu_en = 0.
- Undefined: every opcode is written unchecked, and error can only come from a memory-full load with no halt.

Decomposition:
- Shared package bip_pkg holds:
  - OPCODE_W, OPERAND_W and INSTR_W;
  - opcode constants OP_HLT=0, OP_STO=1, OP_LD=2, OP_LDI=3, OP_ADD=4, OP_ADDI=5, OP_SUB=6, OP_SUBI=7, and OP_LAST_VALID=7;
  - the loader state encoding.
- The decoder and the loader both take their opcode values from bip_pkg.
- No sub-module: one FSM plus a datapath of two byte registers, the address counter and the instruction counter.

Test Plan:
- Reset, then idle for 5 cycles -> all outputs 0 and rx_ready = 0.
- start, then bytes 0x18,0x05, 0x28,0x0A, 0x00,0x00 back to back -> writes 0x1805@0, 0x280A@1, 0x0000@2, each exactly one cycle after its low byte. Then done = 1, cpu_en = 1, instr_count = 3, error = 0.
- Same stream with rx_valid toggled randomly -> identical writes, and no byte is lost or duplicated.
- ADDR_W = 3, eight non-halt words (0x0801) -> eight writes @0..7, then done = 1, error = 1, cpu_en = 0, instr_count = 8.
- Assert rst after the first byte of word 1 -> IDLE next cycle with pm_we = 0. A new start plus the word 0x0000 writes 0x0000@0.
- With BIP_LOADER_OPCODE_CHECK_EN defined, send 0x40,0x00 (opcode 8) -> no write, error = 1, cpu_en = 0. With the macro undefined, the same stream writes 0x4000@0.

Source files
------------

// File: rtl/bip_pkg.sv
// Shared BIP definitions: instruction field widths, opcode values and the loader state encoding.
// The decoder and the program loader both take their opcode values from here.
package bip_pkg;

    localparam int unsigned OPCODE_W  = 5;
    localparam int unsigned INSTR_W   = 16;
    localparam int unsigned OPERAND_W = INSTR_W - OPCODE_W;

    localparam logic [OPCODE_W-1:0] OP_HLT        = 5'd0;
    localparam logic [OPCODE_W-1:0] OP_STO        = 5'd1;
    localparam logic [OPCODE_W-1:0] OP_LD         = 5'd2;
    localparam logic [OPCODE_W-1:0] OP_LDI        = 5'd3;
    localparam logic [OPCODE_W-1:0] OP_ADD        = 5'd4;
    localparam logic [OPCODE_W-1:0] OP_ADDI       = 5'd5;
    localparam logic [OPCODE_W-1:0] OP_SUB        = 5'd6;
    localparam logic [OPCODE_W-1:0] OP_SUBI       = 5'd7;
    localparam logic [OPCODE_W-1:0] OP_LAST_VALID = 5'd7;

    typedef enum logic [2:0] {
        StIdle,
        StHi,
        StLo,
        StWr,
        StDone
    } loaderStateT;

endpackage

// File: rtl/bip_program_loader.sv
// Packs a byte stream (high byte first) into 16-bit instructions and writes them to program RAM
// until HLT, then raises cpu_en. Define BIP_LOADER_OPCODE_CHECK_EN to reject opcodes above 7.
module bip_program_loader #(
    parameter int unsigned ADDR_W   = 11,
    parameter int unsigned OPCODE_W = bip_pkg::OPCODE_W,
    parameter int unsigned INSTR_W  = bip_pkg::INSTR_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    output logic                rx_ready,
    output logic                pm_we,
    output logic [ADDR_W-1:0]   pm_addr,
    output logic [INSTR_W-1:0]  pm_wdata,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [ADDR_W:0]     instr_count,
    output logic                cpu_en
);
    import bip_pkg::*;

    loaderStateT         state;
    logic [7:0]          hiByte;
    logic [INSTR_W-1:0]  newWord;
    logic [OPCODE_W-1:0] wrOpcode;

    assign newWord  = {hiByte, rx_data};
    assign wrOpcode = pm_wdata[INSTR_W-1 -: OPCODE_W];

    // Every output is a register updated alongside the state, so rx_ready never sees rx_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= StIdle;
            hiByte      <= '0;
            rx_ready    <= 1'b0;
            pm_we       <= 1'b0;
            pm_addr     <= '0;
            pm_wdata    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            instr_count <= '0;
            cpu_en      <= 1'b0;
        end else begin
            pm_we <= 1'b0;
            unique case (state)
                StIdle, StDone: begin
                    if (start) begin
                        state       <= StHi;
                        rx_ready    <= 1'b1;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        error       <= 1'b0;
                        cpu_en      <= 1'b0;
                        pm_addr     <= '0;
                        instr_count <= '0;
                    end
                end
                StHi: begin
                    if (rx_valid) begin
                        hiByte <= rx_data;
                        state  <= StLo;
                    end
                end
                StLo: begin
                    if (rx_valid) begin
                        pm_wdata <= newWord;
`ifdef BIP_LOADER_OPCODE_CHECK_EN
                        pm_we    <= (newWord[INSTR_W-1 -: OPCODE_W] <= OP_LAST_VALID);
`else
                        pm_we    <= 1'b1;
`endif
                        rx_ready <= 1'b0;
                        state    <= StWr;
                    end
                end
                StWr: begin
                    // HLT is checked first so a halt in the last slot still counts as clean.
                    if (wrOpcode == OP_HLT) begin
                        instr_count <= instr_count + 1'b1;
                        state       <= StDone;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        cpu_en      <= 1'b1;
                    end
`ifdef BIP_LOADER_OPCODE_CHECK_EN
                    else if (wrOpcode > OP_LAST_VALID) begin
                        state <= StDone;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        error <= 1'b1;
                    end
`endif
                    else if (pm_addr == {ADDR_W{1'b1}}) begin
                        instr_count <= instr_count + 1'b1;
                        state       <= StDone;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        error       <= 1'b1;
                    end else begin
                        instr_count <= instr_count + 1'b1;
                        pm_addr     <= pm_addr + 1'b1;
                        state       <= StHi;
                        rx_ready    <= 1'b1;
                    end
                end
                default: begin
                    state    <= StIdle;
                    rx_ready <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bip_program_loader.sv
// Randomized self-checking bench for bip_program_loader with a small (ADDR_W = 3) memory.
// Expected writes and flags come from a word-level model of the load rules.
module tb_bip_program_loader;

    localparam int unsigned AW    = 3;
    localparam int          Depth = 1 << AW;
`ifdef BIP_LOADER_OPCODE_CHECK_EN
    localparam bit CheckOps = 1'b1;
`else
    localparam bit CheckOps = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [7:0]    rx_data = '0;
    logic          rx_valid = 1'b0;
    logic          rx_ready;
    logic          pm_we;
    logic [AW-1:0] pm_addr;
    logic [15:0]   pm_wdata;
    logic          busy;
    logic          done;
    logic          error;
    logic [AW:0]   instr_count;
    logic          cpu_en;

    bip_program_loader #(.ADDR_W(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .pm_we       (pm_we),
        .pm_addr     (pm_addr),
        .pm_wdata    (pm_wdata),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .instr_count (instr_count),
        .cpu_en      (cpu_en)
    );

    always #5 clk = ~clk;

    int nTests = 0;
    int nFail  = 0;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Observation of the DUT: writes, accepted bytes, write latency, busy/cpu_en overlap.
    int          cyc = 0;
    int          lastXfer = -10;
    int          overlapCnt = 0;
    int          gotAddr[$];
    logic [15:0] gotData[$];
    logic [7:0]  gotBytes[$];
    logic [15:0] prog[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (pm_we === 1'b1) begin
            gotAddr.push_back(int'(pm_addr));
            gotData.push_back(pm_wdata);
            checkEq("wrLatency", lastXfer, cyc - 1);
        end
        if (rx_valid && rx_ready) begin
            gotBytes.push_back(rx_data);
            lastXfer = cyc;
        end
        if (busy && cpu_en) overlapCnt++;
    end

    task automatic pulseStart();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic sendBytes(input logic [7:0] bl[$], input bit randValid);
        int  i = 0;
        int  spent = 0;
        bit  take;
        while (i < bl.size() && spent < 400) begin
            rx_data  = bl[i];
            rx_valid = randValid ? ($urandom_range(0, 1) == 1) : 1'b1;
            take     = rx_valid && rx_ready;
            @(posedge clk); #1;
            spent++;
            if (take) i++;
        end
        rx_valid = 1'b0;
        checkEq("bytesSent", i, bl.size());
    endtask

    task automatic clearObs();
        gotAddr.delete();
        gotData.delete();
        gotBytes.delete();
        overlapCnt = 0;
    endtask

    // Model: words are written at 0,1,2..; load ends at HLT (clean), an out-of-ISA opcode
    // when checking is enabled (no write, error), or after the last address (error).
    task automatic runLoad(input string tag, input bit randValid);
        logic [7:0]  bl[$];
        int          expAddr[$];
        logic [15:0] expData[$];
        logic [4:0]  op;
        bit          expErr = 1'b0;
        bit          expCpu = 1'b0;
        int          n;
        int          waited = 0;
        for (int k = 0; k < prog.size(); k++) begin
            op = prog[k][15:11];
            bl.push_back(prog[k][15:8]);
            bl.push_back(prog[k][7:0]);
            if (CheckOps && op > 5'd7) begin
                expErr = 1'b1;
                break;
            end
            expAddr.push_back(k);
            expData.push_back(prog[k]);
            if (op == 5'd0) begin
                expCpu = 1'b1;
                break;
            end
            if (k == Depth - 1) begin
                expErr = 1'b1;
                break;
            end
        end
        clearObs();
        pulseStart();
        sendBytes(bl, randValid);
        while (done !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checkEq({tag, ".doneSeen"}, done, 1'b1);
        checkEq({tag, ".nWrites"}, gotData.size(), expData.size());
        n = (gotData.size() < expData.size()) ? gotData.size() : expData.size();
        for (int i = 0; i < n; i++) begin
            checkEq({tag, ".addr"}, gotAddr[i], expAddr[i]);
            checkEq({tag, ".data"}, gotData[i], expData[i]);
        end
        checkEq({tag, ".nBytes"}, gotBytes.size(), bl.size());
        n = (gotBytes.size() < bl.size()) ? gotBytes.size() : bl.size();
        for (int i = 0; i < n; i++) checkEq({tag, ".byte"}, gotBytes[i], bl[i]);
        checkEq({tag, ".error"}, error, expErr);
        checkEq({tag, ".cpuEn"}, cpu_en, expCpu);
        checkEq({tag, ".count"}, instr_count, expData.size());
        checkEq({tag, ".busy"}, busy, 1'b0);
        checkEq({tag, ".rxReady"}, rx_ready, 1'b0);
        repeat (3) @(negedge clk);
        checkEq({tag, ".doneHeld"}, done, 1'b1);
        checkEq({tag, ".cpuHeld"}, cpu_en, expCpu);
        checkEq({tag, ".overlap"}, overlapCnt, 0);
    endtask

    initial begin
        logic [7:0]  partial[$];
        logic [15:0] w;
        int          len;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        checkEq("rst.rxReady", rx_ready, 1'b0);
        checkEq("rst.pmWe", pm_we, 1'b0);
        checkEq("rst.pmAddr", pm_addr, 0);
        checkEq("rst.pmWdata", pm_wdata, 0);
        checkEq("rst.busy", busy, 1'b0);
        checkEq("rst.done", done, 1'b0);
        checkEq("rst.error", error, 1'b0);
        checkEq("rst.count", instr_count, 0);
        checkEq("rst.cpuEn", cpu_en, 1'b0);

        prog.delete();
        prog.push_back(16'h1805);
        prog.push_back(16'h280A);
        prog.push_back(16'h0000);
        runLoad("basic", 1'b0);
        runLoad("basicRandValid", 1'b1);

        prog.delete();
        repeat (Depth) prog.push_back(16'h0801);
        runLoad("full", 1'b0);

        prog.delete();
        repeat (Depth - 1) prog.push_back(16'h0801);
        prog.push_back(16'h0000);
        runLoad("fullHlt", 1'b1);

        // Reset after the high byte of word 1; the partial byte must be discarded.
        clearObs();
        pulseStart();
        partial.push_back(8'h18);
        partial.push_back(8'h05);
        partial.push_back(8'h28);
        sendBytes(partial, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checkEq("midRst.pmWe", pm_we, 1'b0);
        checkEq("midRst.busy", busy, 1'b0);
        checkEq("midRst.rxReady", rx_ready, 1'b0);
        checkEq("midRst.count", instr_count, 0);
        prog.delete();
        prog.push_back(16'h0000);
        runLoad("afterRst", 1'b0);

        prog.delete();
        prog.push_back(16'h4000);
        prog.push_back(16'h0000);
        runLoad("badOpcode", 1'b0);

        for (int t = 0; t < 12; t++) begin
            prog.delete();
            len = $urandom_range(1, Depth + 1);
            for (int k = 0; k < len; k++) begin
                w = 16'($urandom);
                w[15:11] = 5'($urandom_range(1, 9));
                prog.push_back(w);
            end
            if ($urandom_range(0, 1) == 1) prog[len - 1][15:11] = 5'd0;
            prog.push_back(16'h0000);
            runLoad("rand", 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
